// File: rtl/integ_pkg.sv
// integ_pkg: shared FSM encoding and default sizing for the integration sequencer
package integ_pkg;
  localparam int N_DEF = 64;
  localparam int CAL_LOG2_DEF = 4;
  localparam int RUN_LEN_DEF = 1024;
  typedef enum logic [2:0] {IDLE, CLEAR, CALIB, PRIME, RUN, DONE} state_t;
endpackage

// File: rtl/integ_seq_ctrl_if.sv
// integ_seq_ctrl_if: sample stream handshake and integrator drive bundle
interface integ_seq_ctrl_if import integ_pkg::*; #(parameter int N = N_DEF);
  logic smp_valid, smp_ready, integ_clear, integ_en;
  logic [N-1:0] smp_data, integ_sample;
  modport master(output smp_valid, smp_data, input smp_ready, integ_clear, integ_en, integ_sample);
  modport slave(input smp_valid, smp_data, output smp_ready, integ_clear, integ_en, integ_sample);
endinterface

// File: rtl/bias_estimator.sv
// bias_estimator: averages 2^CAL_LOG2 signed samples into a floor-rounded bias
module bias_estimator import integ_pkg::*; #(
  parameter int N = N_DEF,
  parameter int CAL_LOG2 = CAL_LOG2_DEF
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         clear,
  input  logic         en,
  input  logic [N-1:0] sample,
  output logic         last,
  output logic [N-1:0] bias
);
  localparam int W = N + CAL_LOG2;
  localparam int CNT_MAX = (1 << CAL_LOG2) - 1;
  logic signed [W-1:0] acc, sum;
  logic [CAL_LOG2:0] cnt;
  assign sum = acc + W'($signed(sample));
  assign last = en && int'(cnt) == CNT_MAX;
  // dropping the low CAL_LOG2 bits of the signed sum is an arithmetic shift (floor)
  always_ff @(posedge clk)
    if (!resetb) begin
      acc <= '0;
      cnt <= '0;
      bias <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (en) begin
      acc <= last ? '0 : sum;
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) bias <= sum[W-1:CAL_LOG2];
    end
endmodule

// File: rtl/integ_seq_ctrl.sv
// integ_seq_ctrl: clear/calibrate/prime/run sequencer feeding a downstream integrator
// INTEG_SAT_EN: saturate the bias-corrected sample instead of wrapping
module integ_seq_ctrl import integ_pkg::*; #(
  parameter int N = N_DEF,
  parameter int CAL_LOG2 = CAL_LOG2_DEF,
  parameter int RUN_LEN = RUN_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  cmd_start,
  input  logic                  cmd_abort,
  integ_seq_ctrl_if.slave       bus,
  output logic [N-1:0]          bias,
  output logic                  busy,
  output logic                  done
);
  localparam logic [15:0] RUN_LAST = 16'(RUN_LEN - 1);
  state_t state;
  logic [15:0] cnt;
  logic take, cal_last;
  logic [N-1:0] corr;
  assign take = bus.smp_valid && bus.smp_ready;
`ifdef INTEG_SAT_EN
  logic [N:0] diff;
  assign diff = {bus.smp_data[N-1], bus.smp_data} - {bias[N-1], bias};
  assign corr = diff[N] != diff[N-1] ? {diff[N], {(N-1){~diff[N]}}} : diff[N-1:0];
`else
  assign corr = bus.smp_data - bias;
`endif
  bias_estimator #(.N(N), .CAL_LOG2(CAL_LOG2)) u_bias (
    .clk(clk),
    .resetb(resetb),
    .clear(state == CLEAR),
    .en(take && state == CALIB && !cmd_abort),
    .sample(bus.smp_data),
    .last(cal_last),
    .bias(bias)
  );
  always_ff @(posedge clk)
    if (!resetb) begin
      state <= IDLE;
      cnt <= '0;
      bus.smp_ready <= 1'b0;
      bus.integ_clear <= 1'b0;
      bus.integ_en <= 1'b0;
      bus.integ_sample <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      bus.integ_en <= 1'b0;
      if (cmd_abort) begin
        state <= IDLE;
        bus.smp_ready <= 1'b0;
        bus.integ_clear <= 1'b0;
        busy <= 1'b0;
        done <= 1'b0;
      end else case (state)
        IDLE: if (cmd_start) begin
          state <= CLEAR;
          bus.integ_clear <= 1'b1;
          busy <= 1'b1;
        end
        CLEAR: begin
          state <= CALIB;
          cnt <= '0;
          bus.integ_clear <= 1'b0;
          bus.smp_ready <= 1'b1;
        end
        CALIB: if (cal_last) state <= PRIME;
        PRIME: if (take) begin
          bus.integ_sample <= corr;
          cnt <= cnt == 16'd1 ? '0 : cnt + 16'd1;
          if (cnt == 16'd1) state <= RUN;
        end
        RUN: if (take) begin
          bus.integ_sample <= corr;
          bus.integ_en <= 1'b1;
          cnt <= cnt == RUN_LAST ? '0 : cnt + 16'd1;
          if (cnt == RUN_LAST) begin
            state <= DONE;
            bus.smp_ready <= 1'b0;
            done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_integ_seq_ctrl.sv
// tb_integ_seq_ctrl: directed checks of calibration, priming, run length, abort, reset and overflow
module tb_integ_seq_ctrl;
  localparam int N = 64;
  logic clk = 1'b0, resetb = 1'b0, cmd_start = 1'b0, cmd_abort = 1'b0;
  logic [N-1:0] bias;
  logic busy, done;
  int vectors = 0, miscompares = 0;
  integ_seq_ctrl_if #(.N(N)) bus();
  integ_seq_ctrl #(.N(N), .CAL_LOG2(4), .RUN_LEN(8)) dut (
    .clk(clk), .resetb(resetb), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .bus(bus), .bias(bias), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [N-1:0] d);
    bus.smp_valid = v;
    bus.smp_data = d;
    step();
    bus.smp_valid = 1'b0;
  endtask

  task automatic start_calib(input logic [N-1:0] a, input logic [N-1:0] b);
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    step();
    for (int i = 0; i < 16; i++) send(1'b1, i[0] ? b : a);
  endtask

  task automatic abort();
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    step();
    step();
    vectors++; if (bus.smp_ready !== 1'b0) begin miscompares++; $display("FAIL reset_smp_ready got %b exp 0", bus.smp_ready); end
    vectors++; if (bus.integ_clear !== 1'b0) begin miscompares++; $display("FAIL reset_integ_clear got %b exp 0", bus.integ_clear); end
    vectors++; if (bus.integ_en !== 1'b0) begin miscompares++; $display("FAIL reset_integ_en got %b exp 0", bus.integ_en); end
    vectors++; if (bus.integ_sample !== '0) begin miscompares++; $display("FAIL reset_integ_sample got %h exp 0", bus.integ_sample); end
    vectors++; if (bias !== '0) begin miscompares++; $display("FAIL reset_bias got %h exp 0", bias); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", done); end
    resetb = 1'b1;
    step();
  endtask

  task automatic test_calib_bias();
    start_calib(64'd100, 64'd100);
    vectors++; if (bias !== 64'd100) begin miscompares++; $display("FAIL calib_bias got %0d exp 100", $signed(bias)); end
    vectors++; if (busy !== 1'b1 || bus.smp_ready !== 1'b1) begin miscompares++; $display("FAIL calib_busy_ready got %b%b exp 11", busy, bus.smp_ready); end
    send(1'b1, 64'd105);
    vectors++; if (bus.integ_sample !== 64'd5) begin miscompares++; $display("FAIL prime_sample got %0d exp 5", $signed(bus.integ_sample)); end
    vectors++; if (bus.integ_en !== 1'b0) begin miscompares++; $display("FAIL prime_en got %b exp 0", bus.integ_en); end
    send(1'b0, 64'd999);
    vectors++; if (bus.integ_sample !== 64'd5 || bus.integ_en !== 1'b0) begin miscompares++; $display("FAIL stall_hold got %0d/%b exp 5/0", $signed(bus.integ_sample), bus.integ_en); end
    send(1'b1, 64'd100);
    vectors++; if (bus.integ_sample !== 64'd0 || bus.integ_en !== 1'b0) begin miscompares++; $display("FAIL prime2 got %0d/%b exp 0/0", $signed(bus.integ_sample), bus.integ_en); end
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 64'(100 + i));
      vectors++; if (bus.integ_en !== 1'b1 || bus.integ_sample !== N'(i)) begin miscompares++; $display("FAIL run_sample%0d got %0d/%b exp %0d/1", i, $signed(bus.integ_sample), bus.integ_en, i); end
      if (i < 7) begin
        send(1'b0, 64'd0);
        vectors++; if (bus.integ_en !== 1'b0) begin miscompares++; $display("FAIL run_stall%0d got %b exp 0", i, bus.integ_en); end
      end
    end
    vectors++; if (done !== 1'b1 || busy !== 1'b1 || bus.smp_ready !== 1'b0) begin miscompares++; $display("FAIL done_state got done=%b busy=%b rdy=%b exp 1 1 0", done, busy, bus.smp_ready); end
    step();
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL idle_after_done got done=%b busy=%b exp 0 0", done, busy); end
    vectors++; if (bias !== 64'd100) begin miscompares++; $display("FAIL bias_kept got %0d exp 100", $signed(bias)); end
  endtask

  task automatic test_run_len();
    int en_cnt = 0, early = 0, done_cnt = 0, done_at = 0;
    start_calib(64'd0, 64'd0);
    bus.smp_valid = 1'b1;
    bus.smp_data = 64'd7;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (bus.integ_en) en_cnt++;
      if (c <= 2 && bus.integ_en) early++;
      if (done) begin done_cnt++; done_at = c; end
    end
    bus.smp_valid = 1'b0;
    vectors++; if (en_cnt !== 8) begin miscompares++; $display("FAIL runlen_en_pulses got %0d exp 8", en_cnt); end
    vectors++; if (early !== 0) begin miscompares++; $display("FAIL runlen_prime_en got %0d exp 0", early); end
    vectors++; if (done_cnt !== 1 || done_at !== 10) begin miscompares++; $display("FAIL runlen_done got count=%0d at=%0d exp 1 at 10", done_cnt, done_at); end
    vectors++; if (busy !== 1'b0 || bus.smp_ready !== 1'b0) begin miscompares++; $display("FAIL runlen_idle got busy=%b rdy=%b exp 0 0", busy, bus.smp_ready); end
    vectors++; if (bus.integ_sample !== 64'd7) begin miscompares++; $display("FAIL runlen_sample got %0d exp 7", $signed(bus.integ_sample)); end
  endtask

  task automatic test_bias_floor();
    start_calib(-64'sd3, -64'sd4);
    vectors++; if (bias !== 64'hFFFF_FFFF_FFFF_FFFC) begin miscompares++; $display("FAIL bias_floor got %0d exp -4", $signed(bias)); end
    abort();
    vectors++; if (busy !== 1'b0 || bus.smp_ready !== 1'b0) begin miscompares++; $display("FAIL floor_abort got busy=%b rdy=%b exp 0 0", busy, bus.smp_ready); end
    vectors++; if (bias !== 64'hFFFF_FFFF_FFFF_FFFC) begin miscompares++; $display("FAIL floor_bias_retained got %0d exp -4", $signed(bias)); end
  endtask

  task automatic test_abort();
    int en_cnt = 0, done_cnt = 0;
    start_calib(64'd10, 64'd10);
    send(1'b1, 64'd10);
    send(1'b1, 64'd10);
    for (int i = 0; i < 4; i++) send(1'b1, 64'd20);
    cmd_abort = 1'b1;
    cmd_start = 1'b1;
    send(1'b1, 64'd20);
    cmd_abort = 1'b0;
    cmd_start = 1'b0;
    vectors++; if (busy !== 1'b0 || bus.smp_ready !== 1'b0) begin miscompares++; $display("FAIL abort_idle got busy=%b rdy=%b exp 0 0", busy, bus.smp_ready); end
    vectors++; if (bus.integ_en !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL abort_outputs got en=%b done=%b exp 0 0", bus.integ_en, done); end
    vectors++; if (bias !== 64'd10) begin miscompares++; $display("FAIL abort_bias got %0d exp 10", $signed(bias)); end
    bus.smp_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.integ_en) en_cnt++;
      if (done) done_cnt++;
    end
    bus.smp_valid = 1'b0;
    vectors++; if (en_cnt !== 0 || done_cnt !== 0) begin miscompares++; $display("FAIL abort_quiet got en=%0d done=%0d exp 0 0", en_cnt, done_cnt); end
  endtask

  task automatic test_reset_midrun();
    start_calib(64'd5, 64'd5);
    send(1'b1, 64'd5);
    send(1'b1, 64'd5);
    for (int i = 0; i < 3; i++) send(1'b1, 64'd6);
    resetb = 1'b0;
    step();
    vectors++; if ({bus.smp_ready, bus.integ_clear, bus.integ_en, busy, done} !== 5'b0) begin miscompares++; $display("FAIL midrun_reset_flags got %b exp 00000", {bus.smp_ready, bus.integ_clear, bus.integ_en, busy, done}); end
    vectors++; if (bus.integ_sample !== '0 || bias !== '0) begin miscompares++; $display("FAIL midrun_reset_data got %h/%h exp 0/0", bus.integ_sample, bias); end
    resetb = 1'b1;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    vectors++; if (bus.integ_clear !== 1'b1 || busy !== 1'b1 || bus.smp_ready !== 1'b0) begin miscompares++; $display("FAIL restart_clear got clr=%b busy=%b rdy=%b exp 1 1 0", bus.integ_clear, busy, bus.smp_ready); end
    step();
    vectors++; if (bus.integ_clear !== 1'b0 || bus.smp_ready !== 1'b1) begin miscompares++; $display("FAIL restart_calib got clr=%b rdy=%b exp 0 1", bus.integ_clear, bus.smp_ready); end
    abort();
  endtask

  task automatic test_sat();
    logic [N-1:0] exp_min;
`ifdef INTEG_SAT_EN
    exp_min = 64'h8000_0000_0000_0000;
`else
    exp_min = 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    start_calib(64'd1, 64'd1);
    vectors++; if (bias !== 64'd1) begin miscompares++; $display("FAIL sat_bias got %0d exp 1", $signed(bias)); end
    send(1'b1, 64'h8000_0000_0000_0000);
    vectors++; if (bus.integ_sample !== exp_min) begin miscompares++; $display("FAIL sat_overflow got %h exp %h", bus.integ_sample, exp_min); end
    send(1'b1, 64'd0);
    vectors++; if (bus.integ_sample !== 64'hFFFF_FFFF_FFFF_FFFF) begin miscompares++; $display("FAIL sat_normal got %h exp ffffffffffffffff", bus.integ_sample); end
    abort();
  endtask

  initial begin
    bus.smp_valid = 1'b0;
    bus.smp_data = '0;
    test_reset();
    test_calib_bias();
    test_run_len();
    test_bias_floor();
    test_abort();
    test_reset_midrun();
    test_sat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/integ_seq_ctrl.md
INTEG_SEQ_CTRL -- requirements
Module: integ_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 64, sample and bias width in bits.
REQ-002 SHALL have parameter CAL_LOG2, default 4; calibration window is 2^CAL_LOG2 samples.
REQ-003 SHALL have parameter RUN_LEN, default 1024; integration-enabled samples per run (1..65535).
REQ-004 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port resetb  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port cmd_start  in  1  single-cycle request to begin a measurement.
REQ-007 SHALL have port cmd_abort  in  1  single-cycle request to terminate the measurement.
REQ-008 SHALL have port smp_valid  in  1  smp_data holds a sample this cycle.
REQ-009 SHALL have port smp_data  in  N  signed two's-complement sample.
REQ-010 SHALL have port smp_ready  out  1  controller accepts samples; a sample is accepted when smp_valid and smp_ready are both high.
REQ-011 SHALL have port integ_clear  out  1  clears the downstream integrator.
REQ-012 SHALL have port integ_en  out  1  drives the integrator start_integration input.
REQ-013 SHALL have port integ_sample  out  N  bias-corrected sample for the integrator.
REQ-014 SHALL have port bias  out  N  calibration result.
REQ-015 SHALL have port busy  out  1  high in every state except IDLE.
REQ-016 SHALL have port done  out  1  one-cycle pulse at run completion.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, CALIB, PRIME, RUN, DONE.
REQ-018 SHALL transition IDLE->CLEAR on cmd_start; in IDLE cmd_start is the only exit, and cmd_start in any other state is ignored.
REQ-019 SHALL hold integ_clear high for exactly the one CLEAR cycle, clear the accumulator and counters, then enter CALIB.
REQ-020 SHALL hold smp_ready high in CALIB, PRIME and RUN only; smp_ready is low in IDLE, CLEAR and DONE.
REQ-021 SHALL, in CALIB, sign-extend each accepted sample into an (N+CAL_LOG2)-bit accumulator; after 2^CAL_LOG2 accepted samples, register bias = accumulator arithmetically shifted right by CAL_LOG2, then enter PRIME.
REQ-022 SHALL, in PRIME, pass exactly two accepted samples with integ_en low to fill the integrator's two-sample history, then enter RUN.
REQ-023 SHALL register integ_sample = smp_data - bias one cycle after every accepted sample in PRIME and RUN; N-bit wrap applies unless REQ-033 applies.
REQ-024 SHALL assert integ_en for exactly one cycle, aligned with integ_sample, one cycle after each sample accepted in RUN; integ_en is low in every other cycle.
REQ-025 SHALL enter DONE once RUN_LEN samples have been accepted in RUN, pulse done for that one cycle, then return to IDLE.
REQ-026 SHALL treat cycles with smp_valid low as stalls: no state, count or output change except integ_en low.
REQ-027 SHALL give cmd_abort priority over everything, including a same-cycle cmd_start and the final RUN sample: next state IDLE, integ_en low, done not pulsed, bias retained.
REQ-028 SHALL keep bias stable from end of CALIB until the next CLEAR.

Reset
REQ-029 SHALL, on resetb low at a clock edge, enter IDLE regardless of state, including mid-run.
REQ-030 SHALL reset every output to 0: smp_ready, integ_clear, integ_en, integ_sample, bias, busy, done.
REQ-031 SHALL reset the accumulator and both counters to 0.

Configuration
REQ-032 SHALL use macro INTEG_SAT_EN to control overflow handling of the bias subtraction.
REQ-033 SHALL, with INTEG_SAT_EN defined, saturate integ_sample to the most positive or most negative N-bit value on overflow.
REQ-034 SHALL, without INTEG_SAT_EN, let integ_sample wrap modulo 2^N.

Structure
REQ-035 SHALL place the FSM state encoding and the default N, CAL_LOG2 and RUN_LEN constants in the shared package integ_pkg.
REQ-036 SHALL implement the calibration accumulator and shift in a sub-module bias_estimator.

Verification
REQ-037 SHALL cover: N=64, CAL_LOG2=4, 16 samples of 100 -> bias=100; then sample 105 -> integ_sample=5.
REQ-038 SHALL cover: RUN_LEN=8, samples every cycle -> exactly 8 integ_en pulses, first 2 post-calibration samples with integ_en low, done pulse, then busy=0.
REQ-039 SHALL cover: calibration samples alternating -3 and -4 -> bias=-4 (arithmetic floor).
REQ-040 SHALL cover: cmd_abort together with the 5th RUN sample -> IDLE next cycle, no further integ_en, done stays 0.
REQ-041 SHALL cover: resetb low mid-RUN, then cmd_start -> all outputs 0, then integ_clear pulses 1 cycle.
REQ-042 SHALL cover: bias=1, sample=0x8000000000000000 -> 0x7FFFFFFFFFFFFFFF without INTEG_SAT_EN; 0x8000000000000000 with it.
